// File: rtl/ysyx_23060124_wbu.sv
// Writeback unit: takes completed instructions from the EXU, waits for LSU load data when needed,
// formats it, drives the register file write port for one cycle and counts retired instructions.
module ysyx_23060124_wbu #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic              exu_wen,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_result,
  input  logic              exu_is_load,
  input  logic [2:0]        exu_load_fmt,
  input  logic [1:0]        exu_addr_lo,
  input  logic              lsu_rvalid,
  input  logic [DATA_W-1:0] lsu_rdata,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] wbu_rd,
  output logic              commit,
  output logic [31:0]       instret
);

  typedef enum logic [1:0] {StIdle, StWaitLoad, StWrite} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          fmt_q, fmt_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [31:0]         instret_q, instret_d;

  logic                accept;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   load_val;

  // Byte/half selection within the aligned word, then sign or zero extension by funct3.
  always_comb begin
    ld_byte = '0;
    unique case (addr_lo_q)
      2'd0: ld_byte = lsu_rdata[7:0];
      2'd1: ld_byte = lsu_rdata[15:8];
      2'd2: ld_byte = lsu_rdata[23:16];
      2'd3: ld_byte = lsu_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
    case (fmt_q)
      3'b000:  load_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101:  load_val = {{(DATA_W-16){1'b0}}, ld_half};
      default: load_val = lsu_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    data_d    = data_q;
    fmt_d     = fmt_q;
    addr_lo_d = addr_lo_q;
    instret_d = instret_q;

    exu_ready = (state_q != StWaitLoad);
    accept    = exu_valid && exu_ready;

    unique case (state_q)
      StWaitLoad: begin
        if (lsu_rvalid) begin
          data_d  = load_val;
          state_d = StWrite;
        end
      end
      StWrite: begin
        instret_d = instret_q + 32'd1;
        state_d   = StIdle;
      end
      default: ;
    endcase

    // Accepting in WRITE overrides the return to IDLE for back-to-back issue.
    if (accept) begin
      rd_d      = exu_wen ? exu_rd : '0;
      data_d    = exu_result;
      fmt_d     = exu_load_fmt;
      addr_lo_d = exu_addr_lo;
      state_d   = exu_is_load ? StWaitLoad : StWrite;
    end
  end

  always_comb begin
    wen     = 1'b0;
    waddr   = '0;
    wdata   = '0;
    commit  = 1'b0;
    wbu_rd  = (state_q == StIdle) ? '0 : rd_q;
    instret = instret_q;
    if (state_q == StWrite) begin
      wen    = (rd_q != '0);
      waddr  = rd_q;
      wdata  = data_q;
      commit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      data_q    <= '0;
      fmt_q     <= '0;
      addr_lo_q <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      fmt_q     <= fmt_d;
      addr_lo_q <= addr_lo_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Directed bench for the writeback unit: inputs driven and outputs sampled on the falling edge.
module tb_ysyx_23060124_wbu;

  logic        clock;
  logic        reset;
  logic        exu_valid;
  logic        exu_ready;
  logic        exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_result;
  logic        exu_is_load;
  logic [2:0]  exu_load_fmt;
  logic [1:0]  exu_addr_lo;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  wbu_rd;
  logic        commit;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_instret = 32'd0;

  ysyx_23060124_wbu #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .exu_valid    (exu_valid),
    .exu_ready    (exu_ready),
    .exu_wen      (exu_wen),
    .exu_rd       (exu_rd),
    .exu_result   (exu_result),
    .exu_is_load  (exu_is_load),
    .exu_load_fmt (exu_load_fmt),
    .exu_addr_lo  (exu_addr_lo),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_rdata    (lsu_rdata),
    .wen          (wen),
    .waddr        (waddr),
    .wdata        (wdata),
    .wbu_rd       (wbu_rd),
    .commit       (commit),
    .instret      (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns at the falling edge after the accept.
  task automatic issue(input logic w, input logic [4:0] rd, input logic [31:0] res,
                       input logic ld, input logic [2:0] fmt, input logic [1:0] alo);
    exu_valid    = 1'b1;
    exu_wen      = w;
    exu_rd       = rd;
    exu_result   = res;
    exu_is_load  = ld;
    exu_load_fmt = fmt;
    exu_addr_lo  = alo;
    @(negedge clock);
    exu_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic exp_wen, input logic [4:0] exp_addr,
                             input logic [31:0] exp_data);
    check_eq({tag, ".wen"}, {31'd0, wen}, {31'd0, exp_wen});
    check_eq({tag, ".waddr"}, {27'd0, waddr}, {27'd0, exp_addr});
    check_eq({tag, ".wdata"}, wdata, exp_data);
    check_eq({tag, ".commit"}, {31'd0, commit}, 32'd1);
    exp_instret = exp_instret + 32'd1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".ready"}, {31'd0, exu_ready}, 32'd1);
    check_eq({tag, ".wen"}, {31'd0, wen}, 32'd0);
    check_eq({tag, ".commit"}, {31'd0, commit}, 32'd0);
    check_eq({tag, ".wbu_rd"}, {27'd0, wbu_rd}, 32'd0);
    check_eq({tag, ".instret"}, instret, exp_instret);
  endtask

  // Load with lsu_rvalid asserted during the accept cycle (must be ignored), then after `gap` waits.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] fmt,
                         input logic [1:0] alo, input logic [31:0] rdata, input int gap,
                         input logic [31:0] exp);
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'hFFFF_FFFF;
    issue(1'b1, rd, 32'hA5A5_A5A5, 1'b1, fmt, alo);
    lsu_rvalid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      check_eq({tag, ".wait_ready"}, {31'd0, exu_ready}, 32'd0);
      check_eq({tag, ".wait_rd"}, {27'd0, wbu_rd}, {27'd0, rd});
      check_eq({tag, ".wait_wen"}, {31'd0, wen}, 32'd0);
      if (i < gap - 1) @(negedge clock);
    end
    lsu_rvalid = 1'b1;
    lsu_rdata  = rdata;
    @(negedge clock);
    lsu_rvalid = 1'b0;
    check_write(tag, 1'b1, rd, exp);
    check_eq({tag, ".wbu_rd"}, {27'd0, wbu_rd}, {27'd0, rd});
    @(negedge clock);
    check_idle({tag, ".after"});
  endtask

  initial begin
    reset        = 1'b1;
    exu_valid    = 1'b0;
    exu_wen      = 1'b0;
    exu_rd       = '0;
    exu_result   = '0;
    exu_is_load  = 1'b0;
    exu_load_fmt = '0;
    exu_addr_lo  = '0;
    lsu_rvalid   = 1'b0;
    lsu_rdata    = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_idle("reset");
    check_eq("reset.waddr", {27'd0, waddr}, 32'd0);
    check_eq("reset.wdata", wdata, 32'd0);

    // Stray rvalid while idle changes nothing.
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h1234_5678;
    @(negedge clock);
    lsu_rvalid = 1'b0;
    check_idle("stray_rvalid");

    issue(1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b000, 2'd0);
    check_write("alu", 1'b1, 5'd5, 32'h1234_5678);
    check_eq("alu.wbu_rd", {27'd0, wbu_rd}, 32'd5);
    @(negedge clock);
    check_idle("alu.after");

    do_load("lb",  5'd3, 3'b000, 2'd2, 32'h0080_0000, 4, 32'hFFFF_FF80);
    do_load("lhu", 5'd4, 3'b101, 2'd2, 32'hBEEF_0000, 2, 32'h0000_BEEF);
    do_load("lh",  5'd6, 3'b001, 2'd0, 32'h1234_8001, 1, 32'hFFFF_8001);
    do_load("lbu", 5'd8, 3'b100, 2'd3, 32'hF0AB_0000, 1, 32'h0000_00F0);
    do_load("lw",  5'd9, 3'b010, 2'd0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

    // Back-to-back ALU ops: one WRITE per cycle.
    exu_valid = 1'b1; exu_wen = 1'b1; exu_is_load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exu_rd     = 5'(i);
      exu_result = 32'h100 + 32'(i);
      @(negedge clock);
      if (i == 3) exu_valid = 1'b0;
      check_write($sformatf("b2b%0d", i), 1'b1, 5'(i), 32'h100 + 32'(i));
      check_eq("b2b.ready", {31'd0, exu_ready}, 32'd1);
    end
    @(negedge clock);
    check_idle("b2b.after");

    issue(1'b1, 5'd0, 32'h0000_0BAD, 1'b0, 3'b000, 2'd0);
    check_write("x0", 1'b0, 5'd0, 32'h0000_0BAD);
    issue(1'b0, 5'd7, 32'h0000_0BAD, 1'b0, 3'b000, 2'd0);
    check_write("nowen", 1'b0, 5'd0, 32'h0000_0BAD);
    @(negedge clock);
    check_idle("nowr.after");

    // Reset during a pending load discards it.
    issue(1'b1, 5'd10, 32'h0, 1'b1, 3'b010, 2'd0);
    check_eq("rst_load.ready", {31'd0, exu_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_instret = 32'd0;
    lsu_rvalid  = 1'b1;
    lsu_rdata   = 32'h5555_5555;
    @(negedge clock);
    lsu_rvalid = 1'b0;
    check_idle("rst_load");
    check_eq("rst_load.wdata", wdata, 32'd0);
    @(negedge clock);
    check_idle("rst_load.after");

    // Preload the counter to its maximum, then retire once to see it wrap.
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clock);
    #1 release dut.instret_q;
    @(negedge clock);
    exp_instret = 32'hFFFF_FFFF;
    check_eq("wrap.preload", instret, 32'hFFFF_FFFF);
    issue(1'b1, 5'd11, 32'h0000_0011, 1'b0, 3'b000, 2'd0);
    check_write("wrap", 1'b1, 5'd11, 32'h0000_0011);
    @(negedge clock);
    check_eq("wrap.instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
